regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL expose parameter XLEN, default 32, register width in bits.
REQ-002 SHALL expose parameter NREGS, default 32, register count (power of two, >=4); AW = clog2(NREGS).
REQ-003 SHALL expose parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL expose parameter NWR, default 2, number of write ports (1..2).
REQ-005 SHALL expose parameter SP_IDX, default 2, index of the register loaded with SP_INIT on clear.
REQ-006 SHALL expose parameter SP_INIT, default 32'h4000, stack-pointer clear value.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst  input  1  reset, synchronous, active-high; starts the clear sweep.
REQ-009 busy  output  1  high while the clear sweep runs; all writes are ignored.
REQ-010 we  input  NWR  per-port write enable.
REQ-011 waddr  input  NWR*AW  per-port write address, port k at bits [k*AW +: AW].
REQ-012 wdata  input  NWR*XLEN  per-port write data, port k at bits [k*XLEN +: XLEN].
REQ-013 raddr  input  NRD*AW  per-port read address, same packing.
REQ-014 rdata  output  NRD*XLEN  per-port read data, same packing, combinational.

Function
REQ-015 Clear FSM SHALL have two states: CLEAR (busy=1) and RUN (busy=0).
REQ-016 On rst=1 at a clock edge: state<=CLEAR, sweep counter<=0; no register write that cycle.
REQ-017 In CLEAR with rst=0: write reg[cnt] <= (cnt==SP_IDX ? SP_INIT : 0), then cnt<=cnt+1; when cnt==NREGS-1, state<=RUN on the same edge.
REQ-018 busy SHALL be high for exactly NREGS cycles after the first edge with rst=0; the first user write is accepted on edge NREGS+1.
REQ-019 rst re-asserted mid-sweep SHALL restart the sweep at cnt=0; registers already cleared stay cleared.
REQ-020 In RUN, port k SHALL write reg[waddr_k] <= wdata_k on the edge when we[k]=1 and waddr_k!=0.
REQ-021 Writes to address 0 SHALL be discarded; reg[0] SHALL always read as 0.
REQ-022 When both write ports target the same nonzero address in a cycle, port 1 SHALL win.
REQ-023 Read port j SHALL return 0 if raddr_j==0 or busy=1.
REQ-024 Otherwise, if any write port k has we[k]=1 and waddr_k==raddr_j (nonzero) in the same cycle, rdata_j SHALL equal wdata_k (write-through bypass), with port 1 taking priority over port 0.
REQ-025 Otherwise rdata_j SHALL equal reg[raddr_j]; read latency is zero cycles.
REQ-026 Unused address bits SHALL NOT exist; all NREGS entries are addressable and no wrap-around logic is applied.

Reset
REQ-027 Reset value of busy SHALL be 1 (state CLEAR); rdata is 0 for all ports while busy.
REQ-028 Array contents before the first sweep completes SHALL NOT be observable on rdata.
REQ-029 No register SHALL depend on an initial block; the sweep is the sole initialisation mechanism.

Structure
REQ-030 Package regfile_pkg SHALL hold the default XLEN, NREGS, SP_IDX, SP_INIT constants and the FSM state encoding (CLEAR=1'b0, RUN=1'b1).
REQ-031 Sub-module regfile_clear_seq SHALL contain the FSM and sweep counter, outputting busy, clr_we, clr_addr and clr_data; the array, write arbitration and bypass SHALL remain in regfile_mp.

Verification
REQ-032 rst for 1 cycle -> busy=1 for 32 cycles, then 0; read x2=32'h4000, x1=0, x31=0.
REQ-033 After clear: we=2'b01, waddr0=5, wdata0=32'hDEADBEEF, raddr0=5 in the same cycle -> rdata0=32'hDEADBEEF (bypass); next cycle with we=0 -> still 32'hDEADBEEF.
REQ-034 we=2'b11, both ports waddr=7, wdata0=32'h1111, wdata1=32'h2222 -> same-cycle read of x7=32'h2222; x7=32'h2222 afterwards.
REQ-035 we=2'b01, waddr0=0, wdata0=32'hFFFFFFFF -> read x0=0 in the same cycle and the next.
REQ-036 Write x3=32'h55 in RUN, then rst at sweep cycle 10 -> busy stays 1 for 32 cycles after rst deasserts; x3=0 and x2=32'h4000 afterwards.
REQ-037 A write attempted while busy=1 (we=1, waddr=9, wdata=32'hAB) -> x9=0 after the sweep completes.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and clear-FSM encoding for the multi-port
// register file.
//   XLEN_DEF    default register width
//   NREGS_DEF   default register count
//   SP_IDX_DEF  default stack-pointer register index
//   SP_INIT_DEF default stack-pointer clear value
//   clr_state_e CLEAR (sweep running) / RUN (normal operation)
package regfile_pkg;

  localparam int          XLEN_DEF    = 32;
  localparam int          NREGS_DEF   = 32;
  localparam int          SP_IDX_DEF  = 2;
  localparam logic [31:0] SP_INIT_DEF = 32'h4000;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: clear sequencer. After reset it walks every register
// index once, emitting one write per cycle (zero, or SP_INIT at SP_IDX), then
// drops busy.
//   clk        rising-edge clock
//   rst        synchronous active-high reset, restarts the sweep
//   busy_o     high while the sweep runs
//   clr_we_o   sweep write strobe
//   clr_addr_o sweep write index
//   clr_data_o sweep write value
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int               XLEN    = XLEN_DEF,
  parameter int               NREGS   = NREGS_DEF,
  parameter int               SP_IDX  = SP_IDX_DEF,
  parameter logic [XLEN-1:0]  SP_INIT = SP_INIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     busy_o,
  output logic                     clr_we_o,
  output logic [$clog2(NREGS)-1:0] clr_addr_o,
  output logic [XLEN-1:0]          clr_data_o
);

  localparam int AW = $clog2(NREGS);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      // NREGS is a power of two, so the counter wraps back to 0 by itself
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(NREGS - 1)) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o     = (state_q == CLEAR);
  // the reset edge itself writes nothing
  assign clr_we_o   = (state_q == CLEAR) && !rst;
  assign clr_addr_o = cnt_q;
  assign clr_data_o = (cnt_q == AW'(SP_IDX)) ? SP_INIT : '0;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NREGS x XLEN register file with NRD combinational read ports
// and NWR write ports. x0 is hardwired to zero. Contents are initialised by
// a clear sweep after reset, during which user writes are dropped and all
// reads return zero. Same-cycle writes are forwarded to matching reads.
//   clk   rising-edge clock
//   rst   synchronous active-high reset (starts clear sweep)
//   busy  high while the clear sweep runs
//   we    per-port write enable
//   waddr per-port write index, port k at [k*AW +: AW]
//   wdata per-port write data,  port k at [k*XLEN +: XLEN]
//   raddr per-port read index,  port j at [j*AW +: AW]
//   rdata per-port read data,   port j at [j*XLEN +: XLEN]
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int               XLEN    = XLEN_DEF,
  parameter int               NREGS   = NREGS_DEF,
  parameter int               NRD     = 2,
  parameter int               NWR     = 2,
  parameter int               SP_IDX  = SP_IDX_DEF,
  parameter logic [XLEN-1:0]  SP_INIT = SP_INIT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           busy,
  input  logic [NWR-1:0]                 we,
  input  logic [NWR*$clog2(NREGS)-1:0]   waddr,
  input  logic [NWR*XLEN-1:0]            wdata,
  input  logic [NRD*$clog2(NREGS)-1:0]   raddr,
  output logic [NRD*XLEN-1:0]            rdata
);

  localparam int AW = $clog2(NREGS);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic [XLEN-1:0] clr_data;

  logic [XLEN-1:0] regs_q [NREGS];

  logic [NWR-1:0][AW-1:0]   wa;
  logic [NWR-1:0][XLEN-1:0] wd;
  logic [NRD-1:0][AW-1:0]   ra;
  logic [NRD-1:0][XLEN-1:0] rd;

  assign wa    = waddr;
  assign wd    = wdata;
  assign ra    = raddr;
  assign rdata = rd;

  regfile_clear_seq #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .SP_IDX  (SP_IDX),
    .SP_INIT (SP_INIT)
  ) u_clr (
    .clk        (clk),
    .rst        (rst),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .clr_data_o (clr_data)
  );

  // Ascending port loop: the highest-numbered port's write lands last and wins.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs_q[clr_addr] <= clr_data;
    end else if (!busy && !rst) begin
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && (wa[k] != '0)) regs_q[wa[k]] <= wd[k];
      end
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    always_comb begin
      rd[j] = regs_q[ra[j]];
      // forward same-cycle writes; later ports override earlier ones
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && (wa[k] == ra[j])) rd[j] = wd[k];
      end
      // x0 and anything during the sweep (uninitialised array) read as zero
      if (busy || (ra[j] == '0)) rd[j] = '0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;

  int checks = 0;
  int errors = 0;
  int n;

  regfile_mp dut (
    .clk   (clk),
    .rst   (rst),
    .busy  (busy),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setw(input int p, input logic [4:0] a, input logic [31:0] d);
    waddr[p*5 +: 5]  = a;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    raddr = {a1, a0};
    #1;
  endtask

  // count cycles until busy drops, bounded
  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; we = '0; waddr = '0; wdata = '0; raddr = '0;
    step();
    rst = 1'b0;
    rd2(5'd2, 5'd1);
    chk("reset_busy", {31'd0, busy}, 32'd1);
    chk("busy_rd0", rdata[31:0], 32'd0);
    chk("busy_rd1", rdata[63:32], 32'd0);

    // write attempted throughout the sweep must be dropped
    we = 2'b01; setw(0, 5'd9, 32'hAB);
    wait_busy(n);
    we = 2'b00;
    chk("sweep_len", n, 32);
    chk("run_busy", {31'd0, busy}, 32'd0);

    rd2(5'd2, 5'd1);
    chk("x2_sp", rdata[31:0], 32'h4000);
    chk("x1_zero", rdata[63:32], 32'd0);
    rd2(5'd31, 5'd9);
    chk("x31_zero", rdata[31:0], 32'd0);
    chk("x9_busy_write", rdata[63:32], 32'd0);

    // single write with bypass on both read ports
    we = 2'b01; setw(0, 5'd5, 32'hDEADBEEF);
    rd2(5'd5, 5'd5);
    chk("byp_rd0", rdata[31:0], 32'hDEADBEEF);
    chk("byp_rd1", rdata[63:32], 32'hDEADBEEF);
    step(); we = 2'b00; #1;
    chk("x5_stored", rdata[31:0], 32'hDEADBEEF);

    // same-address collision: port 1 wins
    we = 2'b11; setw(0, 5'd7, 32'h1111); setw(1, 5'd7, 32'h2222);
    rd2(5'd7, 5'd5);
    chk("coll_byp", rdata[31:0], 32'h2222);
    chk("x5_other_port", rdata[63:32], 32'hDEADBEEF);
    step(); we = 2'b00; #1;
    chk("coll_stored", rdata[31:0], 32'h2222);

    // distinct-address dual write
    we = 2'b11; setw(0, 5'd6, 32'hA5A5A5A5); setw(1, 5'd8, 32'h5A5A5A5A);
    rd2(5'd6, 5'd8);
    chk("dual_byp0", rdata[31:0], 32'hA5A5A5A5);
    chk("dual_byp1", rdata[63:32], 32'h5A5A5A5A);
    step(); we = 2'b00; rd2(5'd8, 5'd6);
    chk("dual_st0", rdata[31:0], 32'h5A5A5A5A);
    chk("dual_st1", rdata[63:32], 32'hA5A5A5A5);

    // writes to x0 are discarded, including bypass
    we = 2'b01; setw(0, 5'd0, 32'hFFFFFFFF);
    rd2(5'd0, 5'd0);
    chk("x0_byp", rdata[31:0], 32'd0);
    step(); we = 2'b00; #1;
    chk("x0_after", rdata[31:0], 32'd0);

    // write x3, then reset mid-sweep
    we = 2'b01; setw(0, 5'd3, 32'h55);
    step(); we = 2'b00; rd2(5'd3, 5'd2);
    chk("x3_written", rdata[31:0], 32'h55);
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; step(); rst = 1'b0; #1;
    wait_busy(n);
    chk("resweep_len", n, 32);
    rd2(5'd3, 5'd2);
    chk("x3_cleared", rdata[31:0], 32'd0);
    chk("x2_resweep", rdata[63:32], 32'h4000);
    rd2(5'd7, 5'd5);
    chk("x7_cleared", rdata[31:0], 32'd0);
    chk("x5_cleared", rdata[63:32], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
